// File: rtl/osc_pkg.sv
// Shared types and helpers for the harmonic oscillator core.
package osc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP_X  = 3'd2,
    STEP_Y  = 3'd3,
    PUBLISH = 3'd4
  } osc_state_e;

  localparam int OSC_COUNT_LIMIT = 10000;
  localparam int OSC_SHW         = 32;

  // Callers sign-extend into OSC_SHW bits and size-cast the result back to their state width.
  function automatic logic signed [OSC_SHW-1:0] osc_asr(input logic signed [OSC_SHW-1:0] v,
                                                        input logic [3:0]                sh);
    return v >>> sh;
  endfunction

endpackage

// File: rtl/osc_prescaler.sv
// Tick prescaler: counts qualified ticks against the run/brake limit and fires a one-cycle carry.
module osc_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  cnt_en_i,
  input  logic                  brake_i,
  input  logic [PRESCALE_W-1:0] run_lim_i,
  input  logic [PRESCALE_W-1:0] brake_lim_i,
  output logic                  fire_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] lim_sel, lim_eff;
  logic [PRESCALE_W:0]   cnt_nxt;

  assign lim_sel = brake_i ? brake_lim_i : run_lim_i;
  assign lim_eff = (lim_sel == '0) ? PRESCALE_W'(1) : lim_sel;
  assign cnt_nxt = {1'b0, cnt_q} + (PRESCALE_W+1)'(1);
  // >= rather than == so a limit lowered below the current count fires on the next tick.
  assign fire_o  = cnt_en_i && (cnt_nxt >= {1'b0, lim_eff});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)         cnt_d = '0;
    else if (fire_o)   cnt_d = '0;
    else if (cnt_en_i) cnt_d = cnt_nxt[PRESCALE_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/harmonic_oscillator_core.sv
// Magic-circle sine/cosine oscillator with prescaler, wrapping step counter and valid/ready output.
// OSC_OFFSET_BINARY_EN: emit offset-binary samples (MSB inverted) instead of two's complement.
module harmonic_oscillator_core
  import osc_pkg::*;
#(
  parameter int WIDTH       = 17,
  parameter int OUT_WIDTH   = 12,
  parameter int PRESCALE_W  = 8,
  parameter int COUNT_W     = 14,
  parameter int COUNT_LIMIT = OSC_COUNT_LIMIT
) (
  input  logic                  CLK_50M,
  input  logic                  reset_n,
  input  logic                  tick_en,
  input  logic [PRESCALE_W-1:0] prescale_run,
  input  logic [PRESCALE_W-1:0] prescale_brake,
  input  logic                  brake,
  input  logic                  enable,
  input  logic [3:0]            k,
  input  logic                  load,
  input  logic [WIDTH-1:0]      init_amp,
  output logic [OUT_WIDTH-1:0]  sin_out,
  output logic [OUT_WIDTH-1:0]  cos_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COUNT_W-1:0]    step_count,
  output logic                  overrun
);

`ifdef OSC_OFFSET_BINARY_EN
  localparam logic [OUT_WIDTH-1:0] OUT_FLIP = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`else
  localparam logic [OUT_WIDTH-1:0] OUT_FLIP = '0;
`endif

  osc_state_e                  state_q, state_d;
  logic signed [WIDTH-1:0]     x_q, x_d, y_q, y_d;
  logic signed [WIDTH-1:0]     x_step, y_step;
  logic [COUNT_W-1:0]          sc_q, sc_d;
  logic [OUT_WIDTH-1:0]        sin_q, sin_d, cos_q, cos_d;
  logic                        vld_q, vld_d, ovr_q, ovr_d, load_q;
  logic                        fire;

  osc_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
    .clk_i       (CLK_50M),
    .rst_n_i     (reset_n),
    .clr_i       (load),
    .cnt_en_i    (tick_en && enable && (state_q == RUN)),
    .brake_i     (brake),
    .run_lim_i   (prescale_run),
    .brake_lim_i (prescale_brake),
    .fire_o      (fire)
  );

  // Leapfrog: y uses the freshly updated x, which keeps the orbit closed.
  assign x_step = x_q - WIDTH'(osc_asr(OSC_SHW'(y_q), k));
  assign y_step = y_q + WIDTH'(osc_asr(OSC_SHW'(x_q), k));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_q) state_d = RUN;
      RUN:     if (fire)   state_d = STEP_X;
      STEP_X:  state_d = STEP_Y;
      STEP_Y:  state_d = PUBLISH;
      PUBLISH: state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (load) state_d = IDLE;
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    sc_d  = sc_q;
    sin_d = sin_q;
    cos_d = cos_q;
    vld_d = vld_q && !out_ready;
    ovr_d = ovr_q;
    if (load) begin
      x_d   = init_amp;
      y_d   = '0;
      sc_d  = '0;
      ovr_d = 1'b0;
    end else begin
      unique case (state_q)
        STEP_X: x_d = x_step;
        STEP_Y: begin
          y_d  = y_step;
          sc_d = (sc_q == COUNT_W'(COUNT_LIMIT-1)) ? '0 : sc_q + COUNT_W'(1);
        end
        PUBLISH: begin
          if (!vld_q || out_ready) begin
            sin_d = y_q[WIDTH-1 -: OUT_WIDTH] ^ OUT_FLIP;
            cos_d = x_q[WIDTH-1 -: OUT_WIDTH] ^ OUT_FLIP;
            vld_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sc_q    <= '0;
      sin_q   <= OUT_FLIP;
      cos_q   <= OUT_FLIP;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sc_q    <= sc_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      load_q  <= load;
    end
  end

  assign sin_out    = sin_q;
  assign cos_out    = cos_q;
  assign out_valid  = vld_q;
  assign overrun    = ovr_q;
  assign step_count = sc_q;

endmodule

// File: tb/tb_harmonic_oscillator_core.sv
// Directed self-checking bench for harmonic_oscillator_core.
module tb_harmonic_oscillator_core;
  localparam int W = 17, OW = 12, PW = 8, CW = 14;
`ifdef OSC_OFFSET_BINARY_EN
  localparam logic [OW-1:0] FLIP = 12'h800;
`else
  localparam logic [OW-1:0] FLIP = 12'h000;
`endif

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          tick_en = 1'b0, brake = 1'b0, enable = 1'b0, load = 1'b0, out_ready = 1'b0;
  logic [PW-1:0] prun = 8'd1, pbrk = 8'd1;
  logic [3:0]    k = 4'd4;
  logic [W-1:0]  init_amp = '0;
  logic [OW-1:0] sin_out, cos_out;
  logic          out_valid, overrun;
  logic [CW-1:0] step_count;

  int nchk = 0, nfail = 0;
  logic signed [W-1:0] mx = '0, my = '0;

  harmonic_oscillator_core dut (
    .CLK_50M(clk), .reset_n(rst_n), .tick_en(tick_en),
    .prescale_run(prun), .prescale_brake(pbrk), .brake(brake), .enable(enable),
    .k(k), .load(load), .init_amp(init_amp),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid), .out_ready(out_ready),
    .step_count(step_count), .overrun(overrun)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] omap(input logic signed [W-1:0] v);
    logic [W-1:0] t;
    t = v;
    return t[W-1 -: OW] ^ FLIP;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mstep();
    mx = mx - (my >>> k);
    my = my + (mx >>> k);
  endtask

  task automatic pulse();
    tick_en = 1'b1; cyc(); tick_en = 1'b0; cyc(); cyc(); cyc();
  endtask

  // One tick that fires a step; out_ready takes value pr just before the publish edge.
  task automatic step(input logic pr);
    tick_en = 1'b1; cyc(); tick_en = 1'b0; cyc(); cyc();
    out_ready = pr; cyc();
    mstep();
  endtask

  task automatic do_load(input logic [W-1:0] amp);
    load = 1'b1; init_amp = amp; cyc();
    load = 1'b0; cyc();
    mx = amp; my = '0;
  endtask

  task automatic measure(output int n);
    logic [CW-1:0] p;
    p = step_count;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      pulse();
      n++;
      if (step_count != p) break;
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [OW-1:0]        hs, hc;
    logic [CW-1:0]        p;
    logic signed [OW-1:0] sv;
    logic                 neg, pneg;
    int                   n, errs, flips, peak, a;

    #2 rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_sin", sin_out, FLIP);
    chk("rst_cos", cos_out, FLIP);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_count", step_count, 0);
    rst_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
    cyc();
    pulse();
    chk("idle_no_step", step_count, 0);
    chk("idle_no_valid", out_valid, 0);

    // First sample of the test-plan orbit.
    do_load(17'h06000);
    step(1'b1);
    chk("first_cos", cos_out, 12'h300 ^ FLIP);
    chk("first_sin", sin_out, 12'h030 ^ FLIP);
    chk("first_count", step_count, 1);
    chk("first_valid", out_valid, 1);
    cyc();
    chk("valid_clr_after_xfer", out_valid, 0);

    // Backpressure: second publish is dropped, then ready rises with a publish.
    out_ready = 1'b0;
    step(1'b0);
    chk("bp_s1_sin", sin_out, omap(my));
    chk("bp_s1_cos", cos_out, omap(mx));
    chk("bp_s1_overrun", overrun, 0);
    hs = omap(my); hc = omap(mx);
    step(1'b0);
    chk("bp_hold_sin", sin_out, hs);
    chk("bp_hold_cos", cos_out, hc);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_overrun", overrun, 1);
    step(1'b1);
    chk("bp_new_sin", sin_out, omap(my));
    chk("bp_new_cos", cos_out, omap(mx));
    chk("bp_new_valid", out_valid, 1);
    cyc();
    chk("bp_valid_clr", out_valid, 0);
    chk("bp_overrun_sticky", overrun, 1);

    // Prescaler run/brake spacing and mid-count switch.
    prun = 8'd2; pbrk = 8'd200; brake = 1'b0;
    measure(n); chk("spacing_run", n, 2);
    brake = 1'b1;
    measure(n); chk("spacing_brake", n, 200);
    p = step_count;
    repeat (150) pulse();
    chk("brake_mid_hold", step_count, p);
    brake = 1'b0;
    pulse();
    chk("brake_switch_step", step_count, p + 1'b1);
    prun = 8'd0;
    measure(n); chk("limit_zero_as_one", n, 1);

    // Free run: trace against model, sign changes and amplitude.
    prun = 8'd1;
    do_load(17'h06000);
    chk("load_clears_overrun", overrun, 0);
    errs = 0; flips = 0; peak = 0; pneg = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step(1'b1);
      if (sin_out !== omap(my) || cos_out !== omap(mx)) errs++;
      sv = sin_out ^ FLIP;
      neg = sv[OW-1];
      if (i > 0 && neg != pneg) flips++;
      pneg = neg;
      a = sv;
      if (a < 0) a = -a;
      if (a > peak) peak = a;
    end
    chk("free_trace_errs", errs, 0);
    chk("free_sign_flips_37_43", (flips >= 37 && flips <= 43), 1);
    chk("free_peak_3pct", (peak >= 745 && peak <= 791), 1);
    chk("free_count", step_count, 2000);

    // Counter wrap, then load landing in STEP_X.
    do_load(17'h06000);
    repeat (9999) step(1'b1);
    chk("count_9999", step_count, 9999);
    step(1'b1);
    chk("count_wrap", step_count, 0);
    step(1'b1);
    chk("count_after_wrap", step_count, 1);
    tick_en = 1'b1; cyc(); tick_en = 1'b0;
    load = 1'b1; init_amp = 17'h01234; cyc();
    chk("ldx_count", step_count, 0);
    load = 1'b0; cyc();
    mx = 17'h01234; my = '0;
    step(1'b1);
    chk("ldx_cos", cos_out, omap(mx));
    chk("ldx_sin", sin_out, omap(my));
    chk("ldx_count_after", step_count, 1);

    // Asynchronous reset mid-step.
    tick_en = 1'b1; cyc(); tick_en = 1'b0;
    rst_n = 1'b0; #2;
    chk("async_sin", sin_out, FLIP);
    chk("async_cos", cos_out, FLIP);
    chk("async_valid", out_valid, 0);
    chk("async_count", step_count, 0);
    rst_n = 1'b1;
    cyc(); cyc();
    pulse();
    chk("async_idle_count", step_count, 0);
    chk("async_idle_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/harmonic_oscillator_core.md
Name: harmonic_oscillator_core

Overview:
- Parametrised successor to the fixed-width in-phase/quadrature oscillator pair.
- Integrates a digital harmonic oscillator (shift-based "magic circle" leapfrog) and produces sine and cosine samples of configurable width.
- Contains its own rate prescaler with brake, a wrapping step counter, and a valid/ready sample handshake toward the DAC/LCD path.
- Sits between the 50 kHz DAC strobe generator and the DAC/BCD drivers.

Parameters:
- WIDTH, 17, signed state width for x (cos) and y (sin).
- OUT_WIDTH, 12, signed output sample width, OUT_WIDTH <= WIDTH.
- PRESCALE_W, 8, width of the prescale limit inputs.
- COUNT_W, 14, width of the step counter.
- COUNT_LIMIT, 10000, step counter wrap value.

Ports:
- CLK_50M  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick_en  in  1  one-cycle sample strobe (50 kHz).
- prescale_run  in  PRESCALE_W  tick_en pulses per step when not braking.
- prescale_brake  in  PRESCALE_W  tick_en pulses per step when braking.
- brake  in  1  selects prescale_brake.
- enable  in  1  steps are taken only while high.
- k  in  4  shift amount (frequency ~ 2^-k rad/step).
- load  in  1  synchronous level; loads the boundary condition.
- init_amp  in  WIDTH  initial x value.
- sin_out  out  OUT_WIDTH  published sine sample.
- cos_out  out  OUT_WIDTH  published cosine sample.
- out_valid  out  1  sample available.
- out_ready  in  1  consumer accepts the sample.
- step_count  out  COUNT_W  number of steps since load.
- overrun  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - x=0, y=0, prescaler=0, step_count=0.
  - sin_out=0, cos_out=0, out_valid=0, overrun=0.
  - FSM goes to IDLE.
- FSM states: IDLE, RUN, STEP_X, STEP_Y, PUBLISH.
  - IDLE: holds state. A load while in IDLE sets x and y, then moves to RUN on the next cycle.
  - load high in any state:
    - x<=init_amp, y<=0.
    - prescaler<=0, step_count<=0, overrun<=0.
    - FSM goes to IDLE and stays there while load is high.
    - out_valid and output registers are untouched.
  - RUN:
    - On tick_en with enable=1, the prescaler increments.
    - Effective limit L = selected prescale, with 0 treated as 1.
    - When prescaler+1 >= L: prescaler<=0 and go to STEP_X; otherwise prescaler<=prescaler+1.
    - Changing brake or the limit mid-count takes effect at the next tick_en; a count already at or above the new L fires a step on that tick.
    - tick_en with enable=0 is ignored.
  - STEP_X: x <= x - (y >>> k). Arithmetic shift, WIDTH-bit wrap (no saturation unless the optional feature is enabled).
  - STEP_Y:
    - y <= y + (x_new >>> k).
    - step_count increments, wrapping from COUNT_LIMIT-1 to 0.
  - PUBLISH, then back to RUN:
    - Output mapping: sin_out = y[WIDTH-1 -: OUT_WIDTH], cos_out = x[WIDTH-1 -: OUT_WIDTH].
    - If out_valid=0 or out_ready=1: load the outputs and set out_valid=1.
    - Otherwise keep the old outputs, set overrun=1, and continue stepping (sample dropped).
- Step latency: 3 cycles from the qualifying tick_en to updated outputs.
- Handshake:
  - Transfer occurs on any cycle with out_valid & out_ready.
  - out_valid clears after a transfer unless PUBLISH loads a new sample in the same cycle; in that case it stays 1.
  - Outputs are stable while out_valid=1 and out_ready=0.
- tick_en arriving while in STEP_X/STEP_Y/PUBLISH is dropped. Because steps are spaced by at least one tick (20 µs), this cannot occur with a 50 kHz strobe.
- k=0: full-scale rotation (unstable amplitude); legal, not guarded.

Optional Feature:
- Macro: OSC_OFFSET_BINARY_EN.
- Defined: sin_out and cos_out are emitted in offset-binary (MSB inverted) for direct DAC drive; reset value of both outputs is {1'b1, 0...}.
- Undefined: outputs are two's complement as specified above.

Decomposition:
- Package osc_pkg holds:
  - FSM state enum type (IDLE, RUN, STEP_X, STEP_Y, PUBLISH).
  - Default COUNT_LIMIT constant.
  - A function for arithmetic shift-and-truncate.
- One sub-module, osc_prescaler: tick counter, limit select, carry output.

Test Plan:
- Reset with reset_n=0 mid-RUN → all outputs 0 in the same cycle with no clock edge; out_valid=0, FSM in IDLE.
- Load init_amp=17'h06000, k=4, prescale_run=1, out_ready=1 → first sample x=0x6000, y=0x0600; step_count=1 three cycles after tick_en.
- Free run as above for 2000 steps → sin_out changes sign about every 50 steps (period ≈100 steps); peak |y| within ±3% of 0x6000.
- brake=1, prescale_brake=200, prescale_run=2 → step spacing goes from 2 to 200 tick_en pulses; switching back mid-count with prescaler at 150 steps on the next tick.
- Hold out_ready=0 across two publishes → sample 1 held, out_valid=1, overrun=1; raising ready with a simultaneous publish loads the new sample and keeps out_valid=1.
- step_count reaches 9999 → wraps to 0 on the next step; load during STEP_X → x=init_amp, y=0, step_count=0, FSM IDLE.
